// File: rtl/spike_dec_pkg.sv
// Shared types and helpers for the spike rate decoder: send FSM states and
// the saturation ceiling used by the per-channel counters.
package spike_dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } send_state_e;

  function automatic int unsigned sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/spike_ch_counter.sv
// One spike channel: rising-edge detector, saturating window counter with a
// sticky sat bit, and (with SPIKE_DEC_ISI_EN) the minimum inter-spike interval.
module spike_ch_counter
  import spike_dec_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               restart,
  input  logic               spike,
  output logic [COUNT_W-1:0] count,
  output logic               sat
`ifdef SPIKE_DEC_ISI_EN
  ,
  output logic [COUNT_W-1:0] isi
`endif
);

  localparam logic [COUNT_W-1:0] CMAX = COUNT_W'(sat_max(COUNT_W));

  logic               prev_q;
  logic               rise;
  logic               at_max;
  logic [COUNT_W-1:0] cnt_q;
  logic               sat_q;

  // Edges seen while disabled are dropped, but prev still tracks the level.
  assign rise   = en & spike & ~prev_q;
  assign at_max = (cnt_q == CMAX);

  // count/sat include the current cycle's edge so a close-cycle edge lands
  // in the snapshot of the window that is closing.
  assign count = (rise && !at_max) ? cnt_q + COUNT_W'(1) : cnt_q;
  assign sat   = sat_q | (rise & at_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      prev_q <= spike;
      if (restart) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else begin
        cnt_q <= count;
        sat_q <= sat;
      end
    end
  end

`ifdef SPIKE_DEC_ISI_EN
  logic [COUNT_W-1:0] itv_q;
  logic [COUNT_W-1:0] min_q;
  logic               seen_q;

  // itv_q holds the enabled-cycle distance back to the previous edge.
  assign isi = (rise && seen_q && (itv_q < min_q)) ? itv_q : min_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      itv_q  <= '0;
      min_q  <= CMAX;
      seen_q <= 1'b0;
    end else if (en) begin
      if (rise)                itv_q <= COUNT_W'(1);
      else if (itv_q != CMAX)  itv_q <= itv_q + COUNT_W'(1);
      if (restart) begin
        min_q  <= CMAX;
        seen_q <= 1'b0;
      end else if (rise) begin
        min_q  <= isi;
        seen_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike edges per channel over a programmable window and streams the
// per-channel snapshot over valid/ready. Optional ISI tracking: SPIKE_DEC_ISI_EN.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int COUNT_W  = 8,
  parameter  int WINDOW_W = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_CH-1:0]   spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                ovr_clr,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [COUNT_W-1:0]  out_count,
  output logic                out_sat,
  output logic [COUNT_W-1:0]  out_isi,
  output logic                overrun
);

  // ---------------- window timer ----------------
  logic [WINDOW_W-1:0] timer_q, len_q, len_start, len_eff;
  logic                close;

  assign len_start = (window_len == '0) ? WINDOW_W'(1) : window_len;
  // In the first cycle of a window the live length applies; it is latched then.
  assign len_eff   = (timer_q == '0) ? len_start : len_q;
  assign close     = en && (timer_q == len_eff - WINDOW_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      len_q   <= WINDOW_W'(1);
    end else if (en) begin
      if (timer_q == '0) len_q <= len_start;
      timer_q <= close ? '0 : timer_q + WINDOW_W'(1);
    end
  end

  // ---------------- per-channel counters ----------------
  logic [NUM_CH-1:0][COUNT_W-1:0] cnt_w;
  logic [NUM_CH-1:0]              sat_w;
`ifdef SPIKE_DEC_ISI_EN
  logic [NUM_CH-1:0][COUNT_W-1:0] isi_w;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spike_ch_counter #(
      .COUNT_W(COUNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .restart(close),
      .spike  (spike_in[g]),
      .count  (cnt_w[g]),
      .sat    (sat_w[g])
`ifdef SPIKE_DEC_ISI_EN
      ,
      .isi    (isi_w[g])
`endif
    );
  end

  // ---------------- send FSM ----------------
  send_state_e     state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            load, ovr_set, xfer, last;

  assign last = (ch_q == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    load      = 1'b0;
    ovr_set   = 1'b0;
    out_valid = (state_q == SEND);
    xfer      = out_valid && out_ready;
    case (state_q)
      IDLE: begin
        if (close) begin
          load    = 1'b1;
          ch_d    = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer && last) begin
          // Final word leaves this cycle, so a coinciding close is not an overrun.
          ch_d = '0;
          if (close) load = 1'b1;
          else       state_d = IDLE;
        end else begin
          if (xfer)  ch_d = ch_q + CH_W'(1);
          if (close) ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // ---------------- holding bank ----------------
  logic [NUM_CH-1:0][COUNT_W-1:0] bank_cnt;
  logic [NUM_CH-1:0]              bank_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_cnt <= '0;
      bank_sat <= '0;
    end else if (load) begin
      bank_cnt <= cnt_w;
      bank_sat <= sat_w;
    end
  end

  assign out_ch    = ch_q;
  assign out_count = bank_cnt[ch_q];
  assign out_sat   = bank_sat[ch_q];

`ifdef SPIKE_DEC_ISI_EN
  logic [NUM_CH-1:0][COUNT_W-1:0] bank_isi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    bank_isi <= '0;
    else if (load) bank_isi <= isi_w;
  end

  assign out_isi = bank_isi[ch_q];
`else
  assign out_isi = '0;
`endif

  // ---------------- overrun flag ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a window/edge-list model predicts
// every output word each cycle, and literal expectations pin the model.
module tb_spike_rate_decoder;

  localparam int NUM_CH = 2;
  localparam int COUNT_W = 4;
  localparam int WINDOW_W = 8;
  localparam int CMAX = 15;
`ifdef SPIKE_DEC_ISI_EN
  localparam bit ISI_ON = 1'b1;
`else
  localparam bit ISI_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                en = 1'b0;
  logic [NUM_CH-1:0]   spike_in = '0;
  logic [WINDOW_W-1:0] window_len = 8'd10;
  logic                ovr_clr = 1'b0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [0:0]          out_ch;
  logic [COUNT_W-1:0]  out_count;
  logic                out_sat;
  logic [COUNT_W-1:0]  out_isi;
  logic                overrun;

  always #5 clk = ~clk;

  spike_rate_decoder #(
    .NUM_CH  (NUM_CH),
    .COUNT_W (COUNT_W),
    .WINDOW_W(WINDOW_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .spike_in  (spike_in),
    .window_len(window_len),
    .ovr_clr   (ovr_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_count (out_count),
    .out_sat   (out_sat),
    .out_isi   (out_isi),
    .overrun   (overrun)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int ch;
    int cnt;
    int sat;
    int isi;
  } word_t;

  word_t             q[$];
  bit                m_ovr;
  logic [NUM_CH-1:0] m_prev;
  int                pos, win_l;
  int                cnt [NUM_CH];
  int                lastp[NUM_CH];
  int                mind[NUM_CH];

  always @(posedge clk or negedge rst_n) begin
    logic [NUM_CH-1:0] rise;
    bit                ovr_ev;
    word_t             w;
    if (!rst_n) begin
      q.delete();
      m_ovr  = 1'b0;
      m_prev = '0;
      pos    = 0;
      win_l  = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] = 0; lastp[c] = -1; mind[c] = 1 << 30;
      end
    end else begin
      rise   = spike_in & ~m_prev;
      m_prev = spike_in;
      ovr_ev = 1'b0;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (en) begin
        if (pos == 0) win_l = (window_len == 0) ? 1 : int'(window_len);
        for (int c = 0; c < NUM_CH; c++)
          if (rise[c]) begin
            cnt[c]++;
            if (lastp[c] >= 0 && pos - lastp[c] < mind[c]) mind[c] = pos - lastp[c];
            lastp[c] = pos;
          end
        if (pos == win_l - 1) begin
          if (q.size() == 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
              w.ch  = c;
              w.cnt = (cnt[c] > CMAX) ? CMAX : cnt[c];
              w.sat = (cnt[c] > CMAX) ? 1 : 0;
              w.isi = !ISI_ON ? 0 : (cnt[c] < 2) ? CMAX : (mind[c] > CMAX) ? CMAX : mind[c];
              q.push_back(w);
            end
          end else ovr_ev = 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            cnt[c] = 0; lastp[c] = -1; mind[c] = 1 << 30;
          end
          pos = 0;
        end else pos++;
      end
      if (ovr_ev)       m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", out_valid, q.size() != 0);
      if (q.size() != 0 && out_valid) begin
        chk("model_ch", out_ch, q[0].ch);
        chk("model_count", out_count, q[0].cnt);
        chk("model_sat", out_sat, q[0].sat);
        chk("model_isi", out_isi, q[0].isi);
      end
      chk("model_overrun", overrun, m_ovr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [NUM_CH-1:0] s);
    spike_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; spike_in = '0; out_ready = 1'b0; ovr_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic word(input string nm, input int ch, input int c, input int s, input int i);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_ch"}, out_ch, ch);
    chk({nm, "_count"}, out_count, c);
    chk({nm, "_sat"}, out_sat, s);
    chk({nm, "_isi"}, out_isi, i);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wl_tab[5] = '{5, 0, 3, 1, 7};
    logic [15:0] lfsr = 16'hACE1;

    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_count", out_count, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_isi", out_isi, 0);
    chk("rst_overrun", overrun, 0);

    // three separated pulses on ch0, window 10
    window_len = 8'd10; en = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step({1'b0, (i == 1 || i == 4 || i == 7)});
    word("t1_w0", 0, 3, 0, ISI_ON ? 3 : 0);
    step('0);
    word("t1_w1", 1, 0, 0, ISI_ON ? CMAX : 0);
    step('0);
    chk("t1_idle", out_valid, 0);

    // held level counts once; close-cycle pulse stays in the closing window
    do_reset();
    window_len = 8'd10; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      step({1'b0, ((i >= 1 && i <= 5) || i == 9)});
      if (i == 9)  word("t2_w0", 0, 2, 0, ISI_ON ? 8 : 0);
      if (i == 19) word("t2_next", 0, 0, 0, ISI_ON ? CMAX : 0);
    end

    // saturation with COUNT_W=4: 20 edges on ch0, one on ch1
    do_reset();
    window_len = 8'd40; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) step({(i == 5), (i % 2 == 1)});
    word("t3_sat", 0, 15, 1, ISI_ON ? 2 : 0);
    step('0);
    word("t3_ch1", 1, 1, 0, ISI_ON ? CMAX : 0);

    // overrun while stalled; first snapshot survives; ovr_clr clears
    do_reset();
    window_len = 8'd4; en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step({(i == 7), (i == 1 || i == 5 || i == 6)});
      if (i == 3) chk("t4_valid", out_valid, 1);
    end
    chk("t4_overrun", overrun, 1);
    word("t4_w0", 0, 1, 0, ISI_ON ? CMAX : 0);
    out_ready = 1'b1;
    step('0);
    word("t4_w1", 1, 0, 0, ISI_ON ? CMAX : 0);
    step('0);
    chk("t4_drained", out_valid, 0);
    chk("t4_sticky", overrun, 1);
    ovr_clr = 1'b1;
    step('0);
    ovr_clr = 1'b0;
    chk("t4_cleared", overrun, 0);

    // reset in SEND at ch_idx=1 aborts and discards the bank
    do_reset();
    window_len = 8'd3; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step({1'b0, (i == 0 || i == 2)});
    word("t5_w0", 0, 2, 0, ISI_ON ? 2 : 0);
    step('0);
    chk("t5_ch1", out_ch, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ch", out_ch, 0);
    chk("t5_rst_count", out_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step('0);
    chk("t5_post0", out_valid, 0);
    step('0);
    chk("t5_post1", out_valid, 0);
    step('0);
    word("t5_fresh", 0, 0, 0, ISI_ON ? CMAX : 0);

    // ISI: edges at 2, 6, 9 on ch0; single edge on ch1
    do_reset();
    window_len = 8'd20; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step({(i == 4), (i == 2 || i == 6 || i == 9)});
    word("t6_isi0", 0, 3, 0, ISI_ON ? 3 : 0);
    step('0);
    word("t6_isi1", 1, 1, 0, ISI_ON ? CMAX : 0);

    // mixed: en gaps, backpressure, short and zero windows, clears
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 0) window_len = WINDOW_W'(wl_tab[(i / 60) % 5]);
      en        = ((i % 13) != 5) && ((i % 13) != 6);
      out_ready = (i % 9) < 6;
      ovr_clr   = (i % 47) == 0;
      lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      step(lfsr[1:0]);
    end
    ovr_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step('0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
